// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (adds the FAULT state).
package fetch_pkg;

  localparam logic [31:0] INSN_BYTES    = 32'd4;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DROP  = 3'd4,
    FAULT = 3'd5
  } fetch_state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DROP  = 3'd4
  } fetch_state_t;
`endif

endpackage

// File: rtl/fetch_inst_buf.sv
// Output holding register presenting a fetched instruction and its PC to decode.
// load_i captures a new word and raises valid; valid drops on a completed
// handshake (valid & ready) or on discard_i. Word and PC hold while valid is low.
module fetch_inst_buf (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load_i,
  input  logic [31:0] data_i,
  input  logic [31:0] pc_i,
  input  logic        discard_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o
);

  logic        valid_q;
  logic        valid_d;
  logic [31:0] inst_q;
  logic [31:0] pc_q;

  // Next valid: clear on handshake or discard, set on a new load.
  always_comb begin
    valid_d = valid_q;
    if (discard_i || (valid_q && ready_i)) begin
      valid_d = 1'b0;
    end
    if (load_i) begin
      valid_d = 1'b1;
    end
  end

  // Holding registers; word and PC only change on load.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      inst_q  <= 32'd0;
      pc_q    <= 32'd0;
    end else begin
      valid_q <= valid_d;
      if (load_i) begin
        inst_q <= data_i;
        pc_q   <= pc_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign inst_o  = inst_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: owns the PC, issues one word read per
// instruction, and hands the returned word to decode.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect traps
// into a sticky FAULT state instead of being silently aligned).
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. valid, once raised, stays high with stable payload until the
// transfer (imem_req_*, inst_*). imem_rsp_valid has no ready: the unit always
// takes it while a request is outstanding. All outputs come from registers or
// decoded state; no input reaches an output combinationally.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault,
  output logic [2:0]  dbg_state
);

  fetch_state_t state_q;
  fetch_state_t state_d;
  logic [31:0]  pc_q;
  logic [31:0]  pc_d;
  logic         buf_load;
  logic         buf_discard;
  logic [31:0]  redir_tgt;

  // The fetched address is always kept word-aligned.
  assign redir_tgt = redirect_pc & PC_ALIGN_MASK;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_pend_q;
  logic fault_pend_d;
  logic redir_mis;
  assign redir_mis = (redirect_pc[1:0] != 2'b00);
`endif

  // Next-state, next-PC and holding-register control.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_load    = 1'b0;
    buf_discard = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    fault_pend_d = fault_pend_q;
`endif
    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redirect_valid) begin
          pc_d = redir_tgt;
        end
      end
      REQ: begin
        if (redirect_valid) begin
          pc_d = redir_tgt;
          // An accepted request still owes a response that must be dropped.
          state_d = imem_req_ready ? DROP : REQ;
        end else if (imem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_d    = redir_tgt;
          state_d = imem_rsp_valid ? REQ : DROP;
        end else if (imem_rsp_valid) begin
          buf_load = 1'b1;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          // A simultaneous inst_ready still completes the handshake inside
          // the buffer; only the sequential PC step is suppressed.
          pc_d        = redir_tgt;
          buf_discard = 1'b1;
          state_d     = REQ;
        end else if (inst_ready) begin
          pc_d    = pc_q + INSN_BYTES;
          state_d = REQ;
        end
      end
      DROP: begin
        if (redirect_valid) begin
          pc_d = redir_tgt;
        end
        // A response arriving with the redirect settles the outstanding
        // request, so there is nothing left to wait for.
        if (imem_rsp_valid) begin
          state_d = REQ;
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      FAULT: begin
        if (redirect_valid) begin
          pc_d    = redir_tgt;
          state_d = REQ;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

`ifdef FETCH_MISALIGN_TRAP_EN
    // Misaligned redirect: trap now, or after the outstanding response.
    if (redirect_valid) begin
      if (redir_mis) begin
        if ((state_q == REQ && imem_req_ready) ||
            ((state_q == WAIT || state_q == DROP) && !imem_rsp_valid)) begin
          state_d      = DROP;
          fault_pend_d = 1'b1;
        end else begin
          state_d      = FAULT;
          fault_pend_d = 1'b0;
        end
      end else begin
        fault_pend_d = 1'b0;
      end
    end else if (state_q == DROP && imem_rsp_valid && fault_pend_q) begin
      state_d      = FAULT;
      fault_pend_d = 1'b0;
    end
`endif
  end

  // State and PC registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // Remembers that a drained DROP must end in FAULT rather than REQ.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fault_pend_q <= 1'b0;
    end else begin
      fault_pend_q <= fault_pend_d;
    end
  end

  assign fetch_fault = (state_q == FAULT);
`else
  assign fetch_fault = 1'b0;
`endif

  assign imem_req_valid = (state_q == REQ);
  assign imem_addr      = pc_q;
  assign dbg_state      = state_q;

  fetch_inst_buf u_inst_buf (
    .clock     (clock),
    .reset_n   (reset_n),
    .load_i    (buf_load),
    .data_i    (imem_rsp_data),
    .pc_i      (pc_q),
    .discard_i (buf_discard),
    .ready_i   (inst_ready),
    .valid_o   (inst_valid),
    .inst_o    (inst),
    .pc_o      (inst_pc)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small in-order memory responder.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_fault;
  logic [2:0]  dbg_state;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_fault    (fetch_fault),
    .dbg_state      (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] acc_q[$];
  int          hs_cnt = 0;
  bit          pend = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr = 32'd0;
  int          rsp_delay = 1;
  bit          rsp_fired = 1'b0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Decide memory inputs for the coming edge, log accepts and handshakes,
  // then advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    imem_rsp_valid = 1'b0;
    rsp_fired      = 1'b0;
    if (pend) begin
      if (cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word_of(paddr);
        pend           = 1'b0;
        rsp_fired      = 1'b1;
      end else begin
        cnt--;
      end
    end
    if (imem_req_valid && imem_req_ready) begin
      pend  = 1'b1;
      paddr = imem_addr;
      cnt   = rsp_delay - 1;
      acc_q.push_back(imem_addr);
    end
    if (inst_valid && inst_ready) hs_cnt++;
    @(posedge clock);
    #1;
    redirect_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 30 && !inst_valid; i++) tick();
    check(tag, 32'(inst_valid), 1);
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] s_inst;
    logic [31:0] s_pc;
    int          h0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;

    // Reset state
    repeat (3) tick();
    check("rst_req_valid", 32'(imem_req_valid), 0);
    check("rst_addr", imem_addr, RST_PC);
    check("rst_inst_valid", 32'(inst_valid), 0);
    check("rst_inst", inst, 0);
    check("rst_inst_pc", inst_pc, 0);
    check("rst_fault", 32'(fetch_fault), 0);
    check("rst_state", 32'(dbg_state), 0);

    // Sequential fetch after release, ready=1, latency 1
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    rsp_delay      = 1;
    reset_n        = 1'b1;
    tick();
    check("seq_req1", 32'(imem_req_valid), 1);
    check("seq_addr1", imem_addr, RST_PC);
    check("seq_iv1", 32'(inst_valid), 0);
    tick();
    check("seq_iv2", 32'(inst_valid), 0);
    tick();
    check("seq_iv3", 32'(inst_valid), 1);
    check("seq_pc3", inst_pc, RST_PC);
    check("seq_inst3", inst, word_of(RST_PC));
    exp_q.push_back(32'h0040_0000);
    exp_q.push_back(32'h0040_0004);
    exp_q.push_back(32'h0040_0008);
    for (int i = 0; i < 20 && acc_q.size() < 3; i++) tick();
    check("seq_req_count", acc_q.size(), 3);
    while (exp_q.size() > 0) begin
      check("seq_req_addr", (acc_q.size() > 0) ? acc_q.pop_front() : 32'hDEAD_BEEF,
            exp_q.pop_front());
    end
    acc_q.delete();

    // Backpressure in HOLD
    inst_ready = 1'b0;
    wait_valid("bp_valid");
    check("bp_pc", inst_pc, 32'h0040_0008);
    s_inst = inst;
    s_pc   = inst_pc;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_inst_stable", inst, s_inst);
      check("bp_pc_stable", inst_pc, s_pc);
      check("bp_no_req", 32'(imem_req_valid), 0);
    end
    inst_ready = 1'b1;
    tick();
    check("bp_resume_req", 32'(imem_req_valid), 1);
    check("bp_resume_addr", imem_addr, 32'h0040_000C);
    check("bp_resume_iv", 32'(inst_valid), 0);

    // Redirect while WAIT with a 3-cycle response
    rsp_delay = 3;
    tick();
    redirect(32'h0000_1000);
    tick();
    check("rdw_req_a", 32'(imem_req_valid), 0);
    check("rdw_iv_a", 32'(inst_valid), 0);
    tick();
    check("rdw_req_b", 32'(imem_req_valid), 0);
    check("rdw_iv_b", 32'(inst_valid), 0);
    tick();
    check("rdw_late_rsp", 32'(rsp_fired), 1);
    check("rdw_req_c", 32'(imem_req_valid), 1);
    check("rdw_addr_c", imem_addr, 32'h0000_1000);
    check("rdw_iv_c", 32'(inst_valid), 0);
    rsp_delay = 1;
    wait_valid("rdw_valid");
    check("rdw_pc", inst_pc, 32'h0000_1000);
    check("rdw_inst", inst, word_of(32'h0000_1000));

    // Redirect in HOLD together with inst_ready
    h0 = hs_cnt;
    redirect(32'h0000_2000);
    tick();
    check("rdh_hs", hs_cnt, h0 + 1);
    check("rdh_iv", 32'(inst_valid), 0);
    check("rdh_req", 32'(imem_req_valid), 1);
    check("rdh_addr", imem_addr, 32'h0000_2000);
    wait_valid("rdh_valid");
    check("rdh_pc", inst_pc, 32'h0000_2000);
    check("rdh_hs_once", hs_cnt, h0 + 1);

    // PC wrap
    inst_ready = 1'b0;
    redirect(32'hFFFF_FFFC);
    tick();
    check("wrap_req", 32'(imem_req_valid), 1);
    check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    wait_valid("wrap_valid");
    check("wrap_pc", inst_pc, 32'hFFFF_FFFC);
    inst_ready = 1'b1;
    tick();
    check("wrap_next_req", 32'(imem_req_valid), 1);
    check("wrap_next_addr", imem_addr, 32'h0000_0000);

    // Misaligned redirect
    wait_valid("mis_pre_valid");
    inst_ready = 1'b0;
    redirect(32'h0000_1002);
    tick();
`ifdef FETCH_MISALIGN_TRAP_EN
    check("mis_fault", 32'(fetch_fault), 1);
    check("mis_no_req", 32'(imem_req_valid), 0);
    check("mis_iv", 32'(inst_valid), 0);
    acc_q.delete();
    repeat (3) tick();
    check("mis_sticky", 32'(fetch_fault), 1);
    check("mis_no_accepts", acc_q.size(), 0);
    redirect(32'h0000_2000);
    tick();
    check("mis_clear", 32'(fetch_fault), 0);
    check("mis_clear_req", 32'(imem_req_valid), 1);
    check("mis_clear_addr", imem_addr, 32'h0000_2000);
    // Misaligned redirect with a request outstanding drains through DROP
    rsp_delay = 2;
    tick();
    redirect(32'h0000_3001);
    tick();
    check("misd_fault_early", 32'(fetch_fault), 0);
    check("misd_no_req", 32'(imem_req_valid), 0);
    tick();
    check("misd_rsp", 32'(rsp_fired), 1);
    check("misd_fault", 32'(fetch_fault), 1);
`else
    check("mis_fault", 32'(fetch_fault), 0);
    check("mis_req", 32'(imem_req_valid), 1);
    check("mis_addr", imem_addr, 32'h0000_1000);
    wait_valid("mis_valid");
    check("mis_pc", inst_pc, 32'h0000_1000);
    check("mis_inst", inst, word_of(32'h0000_1000));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
